// File: rtl/prim_flop_nsync_filt.sv
// -----------------------------------------------------------------------------
// prim_flop_nsync_filt
//
// Multi-bit level synchroniser with a per-bit stability filter.
// Every bit passes through a Stages-deep flop chain into the destination
// clock domain. A per-bit counter then only lets q_o take a new synchronised
// value once that value has persisted for FiltCycles consecutive cycles.
// FiltCycles = 0 bypasses the filter and leaves a single retiming register.
//
// Optional feature macro: PRIM_SYNC_EDGE_EN
//   defined   : rise_o / fall_o are registered one-cycle pulses that are
//               coincident with the new q_o value.
//   undefined : rise_o / fall_o are tied to zero and no edge flops exist.
//               The ports stay present so instantiations do not change.
//
// Parameters:
//   Width       number of independent bit channels
//   Stages      synchroniser depth, 2..4
//   ResetValue  reset value of sync stages and q_o
//   FiltCycles  cycles a new value must persist, 0..255 (0 = bypass)
//
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input bits
//   q_o     synchronised, filtered level
//   rise_o  one-cycle pulse when q_o[b] goes 0->1
//   fall_o  one-cycle pulse when q_o[b] goes 1->0
// -----------------------------------------------------------------------------
module prim_flop_nsync_filt #(
   parameter int unsigned     Width      = 16,
   parameter int unsigned     Stages     = 2,
   parameter logic [Width-1:0] ResetValue = '0,
   parameter int unsigned     FiltCycles = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o
);

   // Parameter legality checks at elaboration.
   if ((Stages < 2) || (Stages > 4)) begin : gen_stages_err
      $error("prim_flop_nsync_filt: Stages must be in 2..4");
   end

   if (FiltCycles > 255) begin : gen_filt_err
      $error("prim_flop_nsync_filt: FiltCycles must be in 0..255");
   end

   // ---------------------------------------------------------------------------
   // Synchroniser chain
   // ---------------------------------------------------------------------------
   logic [Width-1:0] sync_q [Stages];
   logic [Width-1:0] sync_last;

   // Stage 0 samples d_i directly; each later stage retimes the previous one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Stages; i++) begin
            sync_q[i] <= ResetValue;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int unsigned i = 1; i < Stages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_last = sync_q[Stages-1];

   // ---------------------------------------------------------------------------
   // Stability filter / bypass register
   // ---------------------------------------------------------------------------
   logic [Width-1:0] q_d;
   logic [Width-1:0] q_q;

   if (FiltCycles == 0) begin : gen_bypass
      // No counters: q_o is simply one more register after the chain so that
      // the edge logic sees the same registered structure in both modes.
      always_comb begin
         q_d = sync_last;
      end
   end else begin : gen_filter
      localparam int unsigned CntW =
         ($clog2(FiltCycles + 1) > 1) ? $clog2(FiltCycles + 1) : 1;
      localparam logic [CntW-1:0] CntMax = CntW'(FiltCycles - 1);

      logic [CntW-1:0] cnt_d [Width];
      logic [CntW-1:0] cnt_q [Width];

      // Per-bit counter of consecutive mismatching cycles. Any agreement
      // clears it; reaching F-1 while still mismatching commits the value.
      // The counter never exceeds CntMax, so it cannot wrap.
      always_comb begin
         q_d = q_q;
         for (int unsigned b = 0; b < Width; b++) begin
            cnt_d[b] = '0;
            if (sync_last[b] != q_q[b]) begin
               if (cnt_q[b] == CntMax) begin
                  q_d[b] = sync_last[b];
               end else begin
                  cnt_d[b] = cnt_q[b] + CntW'(1);
               end
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int unsigned b = 0; b < Width; b++) begin
               cnt_q[b] <= '0;
            end
         end else begin
            for (int unsigned b = 0; b < Width; b++) begin
               cnt_q[b] <= cnt_d[b];
            end
         end
      end
   end

   // Filtered output level register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= ResetValue;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

   // ---------------------------------------------------------------------------
   // Edge pulses
   // ---------------------------------------------------------------------------
`ifdef PRIM_SYNC_EDGE_EN
   logic [Width-1:0] rise_q;
   logic [Width-1:0] fall_q;

   // Pulses are captured on the same edge that updates q_q, so each pulse is
   // visible in exactly the cycle the new level first appears. A bit can only
   // move one way per edge, so rise and fall are mutually exclusive.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= q_d & ~q_q;
         fall_q <= ~q_d & q_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = '0;
   assign fall_o = '0;
`endif

endmodule

// File: tb/tb_prim_flop_nsync_filt.sv
// -----------------------------------------------------------------------------
// tb_prim_flop_nsync_filt
//
// Directed bench for prim_flop_nsync_filt. A filtered instance
// (Width=4, Stages=2, FiltCycles=3, ResetValue=4'b0101) and a bypass instance
// (Width=4, Stages=3, FiltCycles=0, ResetValue=4'b0000) are exercised.
// Edge-pulse expectations follow PRIM_SYNC_EDGE_EN.
// -----------------------------------------------------------------------------
module tb_prim_flop_nsync_filt;

`ifdef PRIM_SYNC_EDGE_EN
   localparam bit EdgeEn = 1'b1;
`else
   localparam bit EdgeEn = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] d;
   logic [3:0] q;
   logic [3:0] rise;
   logic [3:0] fall;

   logic       rst_b_n;
   logic [3:0] d_b;
   logic [3:0] q_b;
   logic [3:0] rise_b;
   logic [3:0] fall_b;

   int checks   = 0;
   int failures = 0;

   prim_flop_nsync_filt #(
      .Width      (4),
      .Stages     (2),
      .ResetValue (4'b0101),
      .FiltCycles (3)
   ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (d),
      .q_o    (q),
      .rise_o (rise),
      .fall_o (fall)
   );

   prim_flop_nsync_filt #(
      .Width      (4),
      .Stages     (3),
      .ResetValue (4'b0000),
      .FiltCycles (0)
   ) u_dut_byp (
      .clk_i  (clk),
      .rst_ni (rst_b_n),
      .d_i    (d_b),
      .q_o    (q_b),
      .rise_o (rise_b),
      .fall_o (fall_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected pulse vector, zero when edge outputs are compiled out.
   function automatic logic [3:0] pe(input logic [3:0] v);
      return EdgeEn ? v : 4'b0000;
   endfunction

   // Advance one clock edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic main_edges_quiet(input string tag);
      check({tag, "_rise"}, rise, 4'b0000);
      check({tag, "_fall"}, fall, 4'b0000);
   endtask

   initial begin
      logic [3:0] eq;
      rst_n   = 1'b0;
      rst_b_n = 1'b0;
      d       = 4'b1010;
      d_b     = 4'b0000;

      // Reset held with opposite input pattern.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_q", q, 4'b0101);
         main_edges_quiet("rst");
      end
      check("rst_byp_q", q_b, 4'b0000);

      d       = 4'b0101;
      rst_n   = 1'b1;
      rst_b_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("post_rst_q", q, 4'b0101);
      main_edges_quiet("post_rst");

      // Clean rising edge on bit 1: q changes after edge k+4 (5th tick).
      d = 4'b0111;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("clean_q", q, (i >= 5) ? 4'b0111 : 4'b0101);
         check("clean_rise", rise, pe((i == 5) ? 4'b0010 : 4'b0000));
         check("clean_fall", fall, 4'b0000);
      end

      // Two-cycle pulse on bit 3 is rejected.
      d = 4'b1111;
      tick();
      tick();
      d = 4'b0111;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("glitch_q", q, 4'b0111);
         main_edges_quiet("glitch");
      end

      // Exactly three cycles on bit 3 passes, then falls back.
      d = 4'b1111;
      tick();
      tick();
      tick();
      d = 4'b0111;
      // Three ticks already taken: continue counting from i=4.
      for (int i = 4; i <= 10; i++) begin
         tick();
         eq = ((i >= 5) && (i < 8)) ? 4'b1111 : 4'b0111;
         check("bound_q", q, eq);
         check("bound_rise", rise, pe((i == 5) ? 4'b1000 : 4'b0000));
         check("bound_fall", fall, pe((i == 8) ? 4'b1000 : 4'b0000));
      end

      // Return bit 1 low so it can rise in the independence test.
      d = 4'b0101;
      for (int i = 0; i < 10; i++) tick();
      check("settle_q", q, 4'b0101);

      // Bit 0 falls before edge k, bit 1 rises before edge k+1.
      d = 4'b0100;
      tick();
      d = 4'b0110;
      for (int i = 2; i <= 8; i++) begin
         tick();
         eq = 4'b0100;
         if (i < 5)  eq[0] = 1'b1;
         if (i >= 6) eq[1] = 1'b1;
         check("indep_q", q, eq);
         check("indep_fall", fall, pe((i == 5) ? 4'b0001 : 4'b0000));
         check("indep_rise", rise, pe((i == 6) ? 4'b0010 : 4'b0000));
      end

      // Back to reset value level before the mid-count reset test.
      d = 4'b0101;
      for (int i = 0; i < 10; i++) tick();
      check("settle2_q", q, 4'b0101);

      // Bit 1 rises; reset after two synchronised mismatch cycles.
      d = 4'b0111;
      for (int i = 0; i < 4; i++) tick();
      check("midcnt_pre_q", q, 4'b0101);
      rst_n = 1'b0;
      #1;
      check("midcnt_rst_q", q, 4'b0101);
      main_edges_quiet("midcnt_rst");
      tick();
      tick();
      check("midcnt_hold_q", q, 4'b0101);
      main_edges_quiet("midcnt_hold");
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("midcnt_q", q, (i >= 5) ? 4'b0111 : 4'b0101);
         check("midcnt_rise", rise, pe((i == 5) ? 4'b0010 : 4'b0000));
      end

      // Asynchronous reset takes effect without a clock edge.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_q", q, 4'b0101);
      main_edges_quiet("async_rst");
      tick();
      rst_n = 1'b1;

      // Bypass instance: latency of Stages edges, no filtering.
      d_b = 4'b1111;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("byp_q", q_b, (i >= 4) ? 4'b1111 : 4'b0000);
         check("byp_rise", rise_b, pe((i == 4) ? 4'b1111 : 4'b0000));
         check("byp_fall", fall_b, 4'b0000);
      end

      // Single-cycle low pulse on bit 2 passes through unfiltered.
      d_b = 4'b1011;
      tick();
      d_b = 4'b1111;
      for (int i = 2; i <= 6; i++) begin
         tick();
         check("byp_pulse_q", q_b, (i == 4) ? 4'b1011 : 4'b1111);
         check("byp_pulse_fall", fall_b, pe((i == 4) ? 4'b0100 : 4'b0000));
         check("byp_pulse_rise", rise_b, pe((i == 5) ? 4'b0100 : 4'b0000));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prim_flop_nsync_filt.md
Name: prim_flop_nsync_filt

Overview:
- Parametrised multi-bit synchroniser: configurable depth N-stage flop chain, followed by a per-bit stability (glitch) filter.
- Optional per-bit edge-pulse outputs.
- Successor to the fixed 2-stage synchroniser. Used where asynchronous level inputs (pads, straps, status from other domains) must be synchronised and debounced before use.
- All state lives in the destination clock domain.

Parameters:
- Width, 16, number of independent bit channels.
- Stages, 2, synchroniser depth; legal range 2..4; elaboration error outside this range.
- ResetValue, '0 (Width bits), reset value of every synchroniser stage, filtered output and filter state.
- FiltCycles, 4, consecutive cycles a new synchronised value must persist before q_o accepts it; 0 = filter bypassed; legal 0..255.
- CntW, derived = max(1, $clog2(FiltCycles+1)); localparam, not overridable.

Ports:
- clk_i  input  1  destination clock.
- rst_ni  input  1  asynchronous active-low reset.
- d_i  input  Width  asynchronous input bits.
- q_o  output  Width  synchronised, filtered level.
- rise_o  output  Width  one-cycle pulse when q_o[b] goes 0->1.
- fall_o  output  Width  one-cycle pulse when q_o[b] goes 1->0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_ni), deasserted synchronously by the system.
- Reset values:
  - all sync stages = ResetValue
  - q_o = ResetValue
  - per-bit counters = 0
  - rise_o = fall_o = 0
- Sync chain: Stages flops per bit. sync_q is the last stage. A d_i change set up before edge k appears on sync_q after edge k+Stages-1.
- Filter, FiltCycles = F > 0, per bit b, evaluated every edge:
  - sync_q[b] == q_o[b]: cnt[b] <= 0.
  - sync_q[b] != q_o[b] and cnt[b] < F-1: cnt[b] <= cnt[b]+1.
  - sync_q[b] != q_o[b] and cnt[b] == F-1: q_o[b] <= sync_q[b], cnt[b] <= 0.
  - Net latency from d_i to q_o = Stages+F-1 edges after edge k, for a clean level change.
- Glitch handling:
  - Any return of sync_q[b] to q_o[b] before F mismatching cycles clears cnt[b]; q_o is unchanged.
  - Pulses shorter than F synchronised cycles are suppressed.
  - Exactly F cycles pass.
- Filter bypass, F = 0: no counters are instantiated. q_o is one additional register after sync_q, so latency = Stages edges. Keeping q_o registered keeps the edge logic uniform.
- Per-bit independence: each bit's counter is independent. Simultaneous changes on several bits each complete on their own schedule.
- Counter width: cnt never exceeds F-1, so no wrap-around is possible.
- Reset mid-operation:
  - all counters clear, q_o returns to ResetValue, pending pulses are dropped.
  - after release, the chain refills from d_i. A q_o change then takes the full Stages+F latency.
- No combinational path from d_i to any output.

Optional Feature:
- Macro PRIM_SYNC_EDGE_EN.
- Defined:
  - rise_o[b] = 1 for exactly the cycle after q_o[b] updates 0->1 (registered, coincident with new q_o value visible).
  - fall_o[b] likewise for 1->0.
  - Never both high for the same bit.
- Undefined:
  - rise_o and fall_o tied to '0.
  - no edge-detect flops instantiated.
  - ports remain present so instantiations do not change.

Test Plan (Width=4, Stages=2, FiltCycles=3, ResetValue=4'b0101 unless noted):
- Reset: hold rst_ni=0 with d_i=4'b1010 for 5 cycles -> q_o=4'b0101, rise_o=fall_o=0 throughout. After release with d_i=4'b0101 -> q_o stays 4'b0101.
- Clean edge: d_i[1] 0->1 before edge k, held -> q_o[1]=1 after edge k+4; with PRIM_SYNC_EDGE_EN, rise_o[1]=1 for that one cycle only; other bits unchanged.
- Glitch reject and boundary: d_i[3] high for 2 cycles then low -> q_o[3] stays 0, no pulse. d_i[3] high for exactly 3 cycles -> q_o[3] rises after edge k+4, then falls 3 cycles after the low level reaches sync_q; rise then fall pulses.
- Independent bits: d_i[0] falls at edge k and d_i[1] rises at edge k+1, simultaneous toggles -> q_o[0]=0 after k+4, q_o[1]=1 after k+5, separate pulses.
- Reset mid-count: d_i[1] 0->1, assert rst_ni=0 after 2 synchronised mismatch cycles -> q_o=4'b0101 immediately, no pulse. Release with d_i[1]=1 -> q_o[1]=1 exactly 5 edges after release (2 refill + 3 filter).
- Bypass instance, Stages=3, FiltCycles=0: d_i=4'b1111 before edge k -> q_o=4'b1111 after edge k+3. Single-cycle d_i[2] low pulse propagates unfiltered as a one-cycle q_o[2] low with fall/rise pulses.
